floor_request_queue: RTL

//  Ordered queue of pending floor requests for the 4-floor elevator; sits directly

---
 rtl/floor_request_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/floor_request_queue.sv
// floor_request_queue: FIFO of pending floor requests that feeds floor_comparator.
// The head entry is presented on pos0Mem and retired when deletePos0 is seen.
// When the queue is empty, pos0Mem shows actualFloor so the car stays parked.
// Optional feature: define FRQ_DEDUP_EN to reject requests already in the queue.
module floor_request_queue #(
  parameter int DEPTH   = 4,
  parameter int FLOOR_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FLOOR_W-1:0]       reqFloor,
  input  logic                     reqValid,
  input  logic [FLOOR_W-1:0]       actualFloor,
  input  logic                     deletePos0,
  output logic [FLOOR_W-1:0]       pos0Mem,
  output logic                     pos0Valid,
  output logic [$clog2(DEPTH):0]   queueCount,
  output logic                     queueFull,
  output logic                     reqDropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Circular buffer storage; contents are not reset
  logic [FLOOR_W-1:0] buf_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_hold_q, pop_hold_d;
  logic             req_dropped_q, req_dropped_d;

  logic full;
  logic pop;
  logic push;
  logic dup;

  assign pos0Valid  = (count_q != '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign queueFull  = full;
  assign queueCount = count_q;
  assign reqDropped = req_dropped_q;
  assign pos0Mem    = pos0Valid ? buf_q[rd_ptr_q] : actualFloor;

  // popHold blocks back-to-back pops so a stale deletePos0 cannot retire the new head
  assign pop = deletePos0 && pos0Valid && !pop_hold_q;

`ifdef FRQ_DEDUP_EN
  // An entry matches when it lies inside the valid window and holds the same floor;
  // the head is ignored while it is being popped since it is leaving the queue.
  logic [DEPTH-1:0] match;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] offset;
    assign offset    = PTR_W'(gi) - rd_ptr_q;
    assign match[gi] = ({1'b0, offset} < count_q)
                    && (buf_q[gi] == reqFloor)
                    && !(pop && (offset == '0));
  end
  assign dup = |match;
`else
  assign dup = 1'b0;
`endif

  // A full queue only accepts when a slot is freed in the same cycle
  assign push = reqValid && (!full || pop) && !dup;

  // Next-state computation for pointers, count and status flags
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pop_hold_d    = pop;
    req_dropped_d = reqValid && !push;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state register with asynchronous reset that discards all requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pop_hold_q    <= 1'b0;
      req_dropped_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pop_hold_q    <= pop_hold_d;
      req_dropped_q <= req_dropped_d;
    end
  end

  // Write accepted request into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= reqFloor;
    end
  end

endmodule
